filtro_secuenciador: RTL
========================

// Module: filtro_secuenciador
// PURPOSE
//  Sample-rate sequencer and coefficient bank for the pipelined biquad IIR filter datapath.
//  - Accepts one input sample per strobe and presents it to the filter on uk.
//  - Waits for the filter pipeline to settle, then pulses the filter state-register enable for exactly one cycle.
//  - Captures yk and presents it with a valid pulse.
//  - Holds b0,b1,b2,a1,a2 in registers, writable only while idle.
// PARAMETERS
//  Width          23  sample/coefficient word width, signed two's complement
//  Presicion      14  fractional bits (Q format); 1.0 = 1<<Presicion
//  SETTLE_CYCLES   3  cycles between uk update and enable pulse; legal range 1..15
// PORTS
//  clock        in   1      single system clock, rising edge
//  reset        in   1      synchronous, active-high
//  sample_valid in   1      one-cycle strobe: sample_in is valid
//  sample_in    in   Width  input sample
//  coef_we      in   1      coefficient write strobe
//  coef_sel     in   3      0=b0 1=b1 2=b2 3=a1 4=a2; 5..7 invalid
//  coef_data    in   Width  coefficient value
//  clr_ovr      in   1      clears the overrun flag
//  yk_in        in   Width  filter output yk
//  b0,b1,b2     out  Width  coefficient registers to filter
//  a1,a2        out  Width  coefficient registers to filter
//  uk           out  Width  registered sample to filter
//  enable       out  1      filter state-register enable, one-cycle pulse
//  yk_out       out  Width  captured filter output
//  yk_valid     out  1      one-cycle pulse: yk_out updated
//  busy         out  1      high in every state except IDLE
//  overrun      out  1      sticky: a sample was dropped
//  coef_err     out  1      one-cycle pulse: a coefficient write was rejected
// BEHAVIOUR
//  Reset (sync, wins over all inputs; aborts any sequence immediately)
//  - FSM goes to IDLE.
//  - b0 = 1<<Presicion; b1, b2, a1, a2 = 0 (pass-through filter).
//  - uk, yk_out = 0.
//  - enable, yk_valid, busy, overrun, coef_err = 0.
//  - Settle counter = 0.
//  FSM: IDLE -> SETTLE -> COMMIT -> IDLE
//  - IDLE: if sample_valid, then uk <= sample_in, counter <= SETTLE_CYCLES-1, go to SETTLE.
//  - SETTLE: busy=1. Stay while counter != 0 and decrement it; leave for COMMIT when counter == 0.
//    Occupies exactly SETTLE_CYCLES cycles.
//  - COMMIT: enable=1 for this cycle only; yk_out <= yk_in at the closing edge; next state IDLE.
//  - yk_valid=1 in the first cycle after COMMIT, while already in IDLE.
//    A sample_valid in that same cycle is accepted.
//  Timing
//  - sample_valid in cycle t: uk updates at t+1, enable high in cycle t+1+SETTLE_CYCLES, yk_valid high in cycle t+2+SETTLE_CYCLES.
//  - Maximum throughput: one sample per SETTLE_CYCLES+2 cycles.
//  Overrun
//  - sample_valid while busy=1: sample dropped; uk is unchanged.
//  - overrun <= 1 at the next edge; it stays set until reset or clr_ovr.
//  - clr_ovr and a new drop in the same cycle: overrun stays 1 (set wins).
//  Coefficient writes
//  - Accepted only in IDLE with coef_sel <= 4; the register updates at the next edge.
//  - coef_we in any other state, or with coef_sel 5..7: no register changes; coef_err=1 in the next cycle for one cycle.
//  - coef_we and sample_valid in the same IDLE cycle: both take effect. The new coefficient applies to that sample.
//  Datapath
//  - No arithmetic; all values are passed bit-exact.
//  - uk and the coefficient registers are stable except at the edges described above.
// TESTING
//  1 Reset, then hold 5 cycles -> b0=16384, b1=b2=a1=a2=0, uk=0, yk_out=0, all flags 0, enable never high.
//  2 sample_in=0x01234 at t=10 with SETTLE_CYCLES=3 and yk_in driven to 0x00ABC -> uk=0x01234 from t=11;
//    enable high only at t=14; yk_out=0x00ABC and yk_valid high only at t=15.
//  3 Second sample_valid at t=12 while busy -> dropped, uk stays 0x01234, overrun=1 from t=13;
//    pulse clr_ovr at t=20 -> overrun=0 at t=21.
//  4 Back-to-back: samples at t=10 and t=15 -> both accepted; enable at t=14 and t=19; no overrun.
//  5 coef_we with sel=3 and data=0x7C000 in IDLE -> a1=0x7C000 next cycle.
//    coef_we during SETTLE -> a1 unchanged, coef_err pulse.
//    coef_we with sel=6 -> coef_err pulse, no register changes.
//  6 Reset asserted in SETTLE -> next cycle IDLE; enable and yk_valid never pulse for the aborted sample; coefficients back to reset values.

Source files
------------

// File: rtl/filtro_secuenciador.sv
// Sample-rate sequencer and coefficient bank for a pipelined biquad IIR datapath.
// Presents one sample on uk, waits for the pipeline to settle, pulses enable, then captures yk.
module filtro_secuenciador #(
    parameter int Width         = 23,
    parameter int Presicion     = 14,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [Width-1:0] sample_in,
    input  logic             coef_we,
    input  logic [2:0]       coef_sel,
    input  logic [Width-1:0] coef_data,
    input  logic             clr_ovr,
    input  logic [Width-1:0] yk_in,
    output logic [Width-1:0] b0,
    output logic [Width-1:0] b1,
    output logic [Width-1:0] b2,
    output logic [Width-1:0] a1,
    output logic [Width-1:0] a2,
    output logic [Width-1:0] uk,
    output logic             enable,
    output logic [Width-1:0] yk_out,
    output logic             yk_valid,
    output logic             busy,
    output logic             overrun,
    output logic             coef_err
);

    typedef enum logic [1:0] {IDLE, SETTLE, COMMIT} state_t;

    localparam logic [Width-1:0] ONE      = Width'(64'd1 << Presicion);
    localparam logic [3:0]       CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [Width-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, a1_q, a1_d, a2_q, a2_d;
    logic [Width-1:0] uk_q, uk_d, yk_q, yk_d;
    logic             yk_valid_q, yk_valid_d;
    logic             overrun_q, overrun_d;
    logic             coef_err_q, coef_err_d;
    logic             wr_ok, drop;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        uk_d       = uk_q;
        yk_d       = yk_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        b2_d       = b2_q;
        a1_d       = a1_q;
        a2_d       = a2_q;
        yk_valid_d = 1'b0;
        wr_ok      = coef_we && (state_q == IDLE) && (coef_sel <= 3'd4);
        drop       = sample_valid && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    uk_d    = sample_in;
                    cnt_d   = CNT_INIT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) state_d = COMMIT;
                else               cnt_d   = cnt_q - 4'd1;
            end
            COMMIT: begin
                yk_d       = yk_in;
                yk_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (wr_ok) begin
            case (coef_sel)
                3'd0:    b0_d = coef_data;
                3'd1:    b1_d = coef_data;
                3'd2:    b2_d = coef_data;
                3'd3:    a1_d = coef_data;
                default: a2_d = coef_data;
            endcase
        end

        // A fresh drop outranks a simultaneous clear so no lost sample goes unreported.
        overrun_d  = drop ? 1'b1 : (clr_ovr ? 1'b0 : overrun_q);
        coef_err_d = coef_we && !wr_ok;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            b0_q       <= ONE;
            b1_q       <= '0;
            b2_q       <= '0;
            a1_q       <= '0;
            a2_q       <= '0;
            uk_q       <= '0;
            yk_q       <= '0;
            yk_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            coef_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
            a1_q       <= a1_d;
            a2_q       <= a2_d;
            uk_q       <= uk_d;
            yk_q       <= yk_d;
            yk_valid_q <= yk_valid_d;
            overrun_q  <= overrun_d;
            coef_err_q <= coef_err_d;
        end
    end

    assign b0       = b0_q;
    assign b1       = b1_q;
    assign b2       = b2_q;
    assign a1       = a1_q;
    assign a2       = a2_q;
    assign uk       = uk_q;
    assign yk_out   = yk_q;
    assign yk_valid = yk_valid_q;
    assign overrun  = overrun_q;
    assign coef_err = coef_err_q;
    assign enable   = (state_q == COMMIT);
    assign busy     = (state_q != IDLE);

endmodule
